// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and buffers
// {pc, instruction} pairs toward decode through a small FIFO. It also handles
// redirects, halts and misaligned or out-of-range fetch faults.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 24,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        r_fault_pc;
  logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]        r_fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_last_pc;
  logic [31:0]        r_last_instr;

  logic               w_empty;
  logic               w_full;
  logic               w_aligned;
  logic               w_in_range;
  logic               w_try;
  logic               w_fault_det;
  logic               w_push;
  logic               w_pop;

  // 33-bit sum keeps pc + 3 from wrapping into an apparently in-range value.
  assign w_in_range  = ({1'b0, r_pc} + 33'd3) < 33'(IMEM_BYTES);
  assign w_aligned   = (r_pc[1:0] == 2'b00);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop       = !w_empty && ready_i && !redirect_i;
  assign w_try       = (r_state == ST_RUN) && !redirect_i && !halt_i;
  assign w_fault_det = w_try && !(w_aligned && w_in_range);
  assign w_push      = w_try && w_aligned && w_in_range && (!w_full || w_pop);

  assign imem_addr_o = r_pc;
  assign valid_o     = !w_empty;
  assign fault_o     = (r_state == ST_FAULT);
  assign fault_pc_o  = r_fault_pc;
  // Once drained, decode keeps seeing the last head that was presented.
  assign pc_o        = w_empty ? r_last_pc    : r_fifo_pc[r_rd_ptr];
  assign instr_o     = w_empty ? r_last_instr : r_fifo_instr[r_rd_ptr];

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: redirect always returns to RUN, a bad fetch parks in FAULT
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_i)       w_state_nxt = ST_RUN;
    else if (w_fault_det) w_state_nxt = ST_FAULT;
  end

  // Program counter and faulting PC capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
    end else begin
      if (redirect_i)  r_pc <= redirect_pc_i;
      else if (w_push) r_pc <= r_pc + 32'd4;
      if (w_fault_det) r_fault_pc <= r_pc;
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_pc;
      r_fifo_instr[r_wr_ptr] <= imem_instr_i;
    end
  end

  // Remember the presented head so outputs hold when the FIFO runs dry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_pc    <= '0;
      r_last_instr <= '0;
    end else if (!w_empty) begin
      r_last_pc    <= r_fifo_pc[r_rd_ptr];
      r_last_instr <= r_fifo_instr[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 24;
  localparam int unsigned FIFO_DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          chk_en  = 1'b0;

  // Reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_fault;
  logic [31:0] m_fault_pc;
  logic [63:0] m_last;

  instruction_fetch #(
    .RESET_PC  (RESET_PC),
    .IMEM_BYTES(IMEM_BYTES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imem_addr_o  (imem_addr_o),
    .imem_instr_i (imem_instr_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_i       (halt_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .fault_o      (fault_o),
    .fault_pc_o   (fault_pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = RESET_PC;
    m_fault    = 1'b0;
    m_fault_pc = '0;
    m_last     = '0;
  endtask

  task automatic model_step(input bit redir, input logic [31:0] rpc, input bit halt, input bit rdy);
    bit pop;
    pop = (m_q.size() != 0) && rdy && !redir;
    if (m_q.size() != 0) m_last = m_q[0];
    if (redir) begin
      m_q.delete();
      m_pc    = rpc;
      m_fault = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_fault && !halt) begin
        if ((m_pc % 4 != 0) || (longint'(m_pc) + 3 >= longint'(IMEM_BYTES))) begin
          m_fault    = 1'b1;
          m_fault_pc = m_pc;
        end else if (m_q.size() < FIFO_DEPTH) begin
          m_q.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("valid_o", 32'(valid_o), 32'(m_q.size() != 0));
      chk("pc_o", pc_o, (m_q.size() != 0) ? m_q[0][63:32] : m_last[63:32]);
      chk("instr_o", instr_o, (m_q.size() != 0) ? m_q[0][31:0] : m_last[31:0]);
      chk("fault_o", 32'(fault_o), 32'(m_fault));
      chk("fault_pc_o", fault_pc_o, m_fault_pc);
      chk("imem_addr_o", imem_addr_o, m_pc);
    end
  end

  // One clock: drive inputs, advance the model, return at the next falling edge
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit halt, input bit rdy);
    #1;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    halt_i        = halt;
    ready_i       = rdy;
    model_step(redir, rpc, halt, rdy);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge
  task automatic do_reset();
    #1;
    rst_ni     = 1'b0;
    redirect_i = 1'b0;
    halt_i     = 1'b0;
    ready_i    = 1'b0;
    model_reset();
    #1;
    chk("rst_valid_now", 32'(valid_o), 32'd0);
    chk("rst_addr_now", imem_addr_o, RESET_PC);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  logic [31:0] targets [11] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                                32'h06, 32'h18, 32'h02, 32'h20, 32'hFFFF_FFFC};

  initial begin
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    halt_i        = 1'b0;
    ready_i       = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_pc_o", pc_o, 32'd0);
    chk("reset_addr", imem_addr_o, RESET_PC);
    #1 rst_ni = 1'b1;

    // Streaming through the whole memory into a range fault
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("stream_valid", 32'(valid_o), 32'd1);
      chk("stream_pc", pc_o, 32'(k * 4));
    end
    chk("stream_instr", instr_o, mem_word(32'h14));
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("stream_fault", 32'(fault_o), 32'd1);
    chk("stream_fault_pc", fault_pc_o, 32'h18);
    chk("stream_drained", 32'(valid_o), 32'd0);

    // Backpressure from reset
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("bp_hold_pc", pc_o, 32'h00);
    end
    chk("bp_addr", imem_addr_o, 32'h08);
    chk("bp_valid", 32'(valid_o), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("bp_seq1", pc_o, 32'h04);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("bp_seq2", pc_o, 32'h08);

    // Redirect with a full FIFO
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 1'b0, 1'b1);
    chk("redir_valid", 32'(valid_o), 32'd0);
    chk("redir_addr", imem_addr_o, 32'h10);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("redir_pc", pc_o, 32'h10);

    // Misaligned redirect target, then recovery
    cycle(1'b1, 32'h06, 1'b0, 1'b1);
    chk("mis_nofault_yet", 32'(fault_o), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("mis_fault", 32'(fault_o), 32'd1);
    chk("mis_fault_pc", fault_pc_o, 32'h06);
    chk("mis_valid", 32'(valid_o), 32'd0);
    cycle(1'b1, 32'h04, 1'b0, 1'b1);
    chk("mis_clear", 32'(fault_o), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("mis_resume_pc", pc_o, 32'h04);

    // Halt drains the FIFO and freezes the PC
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("halt_addr", imem_addr_o, 32'h08);
    end
    chk("halt_drained", 32'(valid_o), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("halt_resume_pc", pc_o, 32'h08);

    // Async reset mid-stream with the FIFO full
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("rst_restart_pc", pc_o, 32'h00);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 15) == 0), targets[$urandom_range(0, 10)],
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the byte-addressed instruction memory and downstream-feeding decode.
- Owns the program counter and drives the instruction memory address.
- Captures the returned 32-bit instruction, same cycle, combinational.
- Buffers {pc, instruction} pairs in a small FIFO toward decode with a valid/ready handshake.
- Handles control-flow redirects, fetch halting and fetch faults (misaligned or out-of-range PC).

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
IMEM_BYTES  24  instruction memory size in bytes; a fetch is in range iff pc + 3 < IMEM_BYTES
FIFO_DEPTH  2  entries in the fetch-to-decode buffer (power of two, >= 2)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
imem_addr_o  output  32  byte address to instruction memory (= current PC)
imem_instr_i  input  32  instruction word returned combinationally for imem_addr_o
redirect_i  input  1  branch/jump taken: flush and load new PC
redirect_pc_i  input  32  redirect target byte address
halt_i  input  1  suspend new fetches (buffer still drains)
valid_o  output  1  head FIFO entry valid toward decode
ready_i  input  1  decode accepts head entry
instr_o  output  32  instruction of head entry
pc_o  output  32  PC of head entry
fault_o  output  1  fetch fault latched; fetching stopped
fault_pc_o  output  32  PC that caused the fault

Behaviour:
- Reset (async, rst_ni=0), applies immediately and holds until release:
  - pc = RESET_PC; FIFO empty; state = RUN.
  - valid_o = 0, instr_o = 0, pc_o = 0, fault_o = 0, fault_pc_o = 0; imem_addr_o = RESET_PC.
  - Reset mid-operation discards all buffered entries and any latched fault.
- imem_addr_o = pc register, combinational, no additional latency.
- The memory returns data in the same cycle, so an entry is captured at the clock edge that ends the cycle in which pc was presented.
- States: RUN, FAULT.
- RUN, fetch condition: fetch occurs when all of the following hold:
  - redirect_i = 0
  - halt_i = 0
  - the FIFO has room (not full, or full with a pop in the same cycle)
  - pc[1:0] = 0
  - pc + 3 < IMEM_BYTES
- RUN, on fetch: push {pc, imem_instr_i}; pc <= pc + 4 (32-bit wrap, no saturation).
- RUN, fault: when not redirecting, not halted, and pc is misaligned or out of range:
  - no push; state -> FAULT.
  - fault_o <= 1; fault_pc_o <= pc.
  - Previously buffered entries still drain.
- FAULT:
  - No fetches; pc holds; fault_o stays 1.
  - Only redirect_i (or reset) exits: -> RUN, fault_o <= 0.
- Redirect has the highest priority in any state. In the redirect cycle:
  - FIFO flushed; any pop that cycle is ignored; no push.
  - pc <= redirect_pc_i.
  - valid_o = 0 from the next cycle until the first fetch at the new pc.
  - Alignment and range of the new pc are checked on the following cycle, not at redirect time.
- Decode handshake:
  - valid_o = FIFO not empty; instr_o/pc_o = head entry.
  - The head is held stable while valid_o = 1 and ready_i = 0.
  - Pop iff valid_o & ready_i & !redirect_i.
  - Simultaneous push and pop: count unchanged.
  - Push when full is allowed only with a same-cycle pop.
  - Pop when empty: no effect.
- halt_i = 1: stops pushes only; pops continue; pc holds.
- When the FIFO is empty, instr_o/pc_o hold their last head value, or 0 after reset.
- Throughput: one instruction per cycle sustained while ready_i = 1.
- First valid_o rises one cycle after reset release.

Test Plan:
- Streaming: memory holds 6 words at 0x00..0x14, ready_i = 1, reset release.
  - valid_o rises in cycle 1; pc_o = 0x00, 0x04, ... 0x14 on consecutive cycles.
  - Fault at pc = 0x18: fault_o = 1, fault_pc_o = 0x18.
  - valid_o falls after the 0x14 entry is consumed.
- Backpressure: ready_i = 0 for 5 cycles from reset.
  - FIFO fills with pc 0x00, 0x04; imem_addr_o holds 0x08.
  - valid_o = 1 with pc_o = 0x00 held stable.
  - After ready_i rises, pc_o sequence = 0x00, 0x04, 0x08 with no gap or duplicate.
- Redirect: redirect_i pulse with redirect_pc_i = 0x10 while the FIFO holds 2 entries and ready_i = 1.
  - Next cycle valid_o = 0 and imem_addr_o = 0x10.
  - The following cycle pc_o = 0x10.
  - Old entries never appear on the decode side.
- Misaligned redirect: redirect_pc_i = 0x06.
  - One cycle later fault_o = 1, fault_pc_o = 0x06, no valid_o.
  - A subsequent redirect to 0x04 clears fault_o and gives pc_o = 0x04.
- Halt: halt_i = 1 for 3 cycles with ready_i = 1.
  - imem_addr_o frozen; FIFO drains to valid_o = 0.
  - After release, fetch resumes at the frozen address with no skipped PC.
- Async reset mid-stream: rst_ni low between clock edges with the FIFO full.
  - valid_o = 0 and imem_addr_o = RESET_PC immediately, before the next edge.
  - After release, streaming restarts at 0x00.
